// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM bus between instruction fetch and load/store.
// The data side has fixed priority. Each bus transaction ends on bus_ack_i or
// on a wait timeout. Completion is signalled by a one-cycle ready pulse.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic        err_o
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_MEM
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;
  logic        timed_out;

  // Next-state logic: grant, bus hold, completion on ack or timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    err_d       = 1'b0;
    timed_out   = (TIMEOUT != 0) && (cnt_q == LIMIT);

    unique case (state_q)
      IDLE: begin
        // A requester still seeing its own ready pulse is finishing, not asking again.
        if (mem_req_i && !mem_ready_q) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_sel_d   = mem_sel_i;
          cnt_d       = '0;
          state_d     = BUS_MEM;
        end else if (if_req_i && !if_ready_q) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_sel_d   = 4'b1111;
          cnt_d       = '0;
          state_d     = BUS_IF;
        end
      end
      BUS_IF, BUS_MEM: begin
        if (bus_ack_i || timed_out) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          err_d     = !bus_ack_i;
          if (state_q == BUS_IF) begin
            if_ready_d = 1'b1;
            if_data_d  = bus_ack_i ? bus_rdata_i : '0;
          end else begin
            mem_ready_d = 1'b1;
            mem_rdata_d = (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  // Stall while any requester is still waiting for its completion pulse.
  always_comb begin
    stallreq_o = rst && ((if_req_i && !if_ready_q) || (mem_req_i && !mem_ready_q));
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_sel_o   = bus_sel_q;
  assign if_ready_o  = if_ready_q;
  assign mem_ready_o = mem_ready_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign err_o       = err_q;

endmodule
